// File: rtl/qpsk_frame_sync_pkg.sv
// Shared definitions for the QPSK frame synchroniser: FSM encoding,
// default unique word, symbol geometry and the detector result type.
package qpsk_frame_sync_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } fsm_state_t;

    localparam logic [15:0] HEADER_DEFAULT  = 16'hEB90;
    localparam int          UW_W            = 16;
    localparam int          BITS_PER_SYMBOL = 2;

    // Detector result: match/match_inv refer to the bit slot in position
    // (0 = window closed on the I bit, 1 = window closed on the Q bit).
    typedef struct packed {
        logic match;
        logic match_inv;
        logic position;
    } uw_hit_t;

endpackage

// File: rtl/qpsk_uw_detect.sv
// Combinational unique-word detector. Given the 15 most recent stream bits
// and the I/Q pair of the current symbol, it evaluates both window
// positions of the symbol; the earlier (I) position wins.
module qpsk_uw_detect
    import qpsk_frame_sync_pkg::*;
#(
    parameter logic [15:0] HEADER = HEADER_DEFAULT
) (
    input  logic [14:0] i_window_tail,
    input  logic        i_bit_i,
    input  logic        i_bit_q,
    output uw_hit_t     o_hit
);

    logic [15:0] w_win_i;
    logic [15:0] w_win_q;
    logic        w_hit_i;
    logic        w_hit_i_inv;
    logic        w_hit_q;
    logic        w_hit_q_inv;

    assign w_win_i = {i_window_tail, i_bit_i};
    assign w_win_q = {i_window_tail[13:0], i_bit_i, i_bit_q};

    assign w_hit_i     = (w_win_i == HEADER);
    assign w_hit_i_inv = (w_win_i == ~HEADER);
    assign w_hit_q     = (w_win_q == HEADER);
    assign w_hit_q_inv = (w_win_q == ~HEADER);

    // Prefer a hit closing on the I bit over one closing on the Q bit.
    always_comb begin
        o_hit = '0;
        if (w_hit_i || w_hit_i_inv) begin
            o_hit.match     = w_hit_i;
            o_hit.match_inv = w_hit_i_inv;
            o_hit.position  = 1'b0;
        end else if (w_hit_q || w_hit_q_inv) begin
            o_hit.match     = w_hit_q;
            o_hit.match_inv = w_hit_q_inv;
            o_hit.position  = 1'b1;
        end
    end

endmodule

// File: rtl/qpsk_frame_sync.sv
// QPSK frame synchroniser: serialises I/Q symbols into one bit stream,
// hunts for the unique word (either polarity, either bit phase), then
// assembles payload bytes and verifies the header of every following frame
// with a flywheel of MISS_MAX tolerated misses.
module qpsk_frame_sync
    import qpsk_frame_sync_pkg::*;
#(
    parameter logic [15:0] HEADER        = HEADER_DEFAULT,
    parameter int          PAYLOAD_BYTES = 8,
    parameter int          MISS_MAX      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sync_out_i,
    input  logic       i_sync_out_q,
    input  logic       i_sync_flag,
    output logic [7:0] o_byte_out,
    output logic       o_byte_valid,
    output logic       o_frame_start,
    output logic       o_lock,
    output logic       o_inverted,
    output logic [1:0] o_state
);

    localparam int PAYLOAD_BITS = PAYLOAD_BYTES * 8;
    localparam int CNT_W        = $clog2(PAYLOAD_BITS + UW_W);
    localparam int MISS_W       = $clog2(MISS_MAX + 2);

    // Frame position counter: 0..PAYLOAD_BITS-1 in PAYLOAD, then
    // PAYLOAD_BITS..PAYLOAD_BITS+15 in CHECK.
    fsm_state_t        r_state, n_state;
    logic [CNT_W-1:0]  r_cnt, n_cnt;
    // Only 15 bits of history are stored: the 16th window bit is always the
    // one arriving in the current slot.
    logic [14:0]       r_win;
    logic [15:0]       n_win;
    logic [7:0]        r_sr, n_sr;
    logic              r_inv, n_inv;
    logic [MISS_W-1:0] r_miss, n_miss;

    logic [7:0]        r_byte_out;
    logic              r_byte_valid;
    logic              r_frame_start;

    logic              w_bit;
    logic              w_byte_done;
    logic              w_byte_first;
    logic [7:0]        w_byte_data;
    uw_hit_t           w_hit;

    qpsk_uw_detect #(
        .HEADER (HEADER)
    ) u_uw_detect (
        .i_window_tail (r_win),
        .i_bit_i       (i_sync_out_i),
        .i_bit_q       (i_sync_out_q),
        .o_hit         (w_hit)
    );

    // Next-state: walk the two bit slots of the symbol (I then Q) in order,
    // so a state change on the I bit governs how the Q bit is consumed.
    always_comb begin
        n_state      = r_state;
        n_cnt        = r_cnt;
        n_win        = {1'b0, r_win};
        n_sr         = r_sr;
        n_inv        = r_inv;
        n_miss       = r_miss;
        w_bit        = 1'b0;
        w_byte_done  = 1'b0;
        w_byte_first = 1'b0;
        w_byte_data  = 8'h00;
        if (i_sync_flag) begin
            for (int k = 0; k < BITS_PER_SYMBOL; k++) begin
                w_bit = (k == 0) ? i_sync_out_i : i_sync_out_q;
                case (n_state)
                    ST_SEARCH: begin
                        n_win = {n_win[14:0], w_bit};
                        // The detector sees the registered window, so it is
                        // only meaningful if the symbol began in SEARCH.
                        if ((r_state == ST_SEARCH) &&
                            (w_hit.match || w_hit.match_inv) &&
                            (w_hit.position == 1'(k))) begin
                            n_state = ST_PAYLOAD;
                            n_inv   = w_hit.match_inv;
                            n_cnt   = '0;
                            n_sr    = '0;
                            n_miss  = '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        n_sr = {n_sr[6:0], w_bit ^ n_inv};
                        if (n_cnt[2:0] == 3'b111) begin
                            w_byte_done  = 1'b1;
                            w_byte_data  = n_sr;
                            w_byte_first = (n_cnt == CNT_W'(7));
                        end
                        if (n_cnt == CNT_W'(PAYLOAD_BITS - 1)) begin
                            n_state = ST_CHECK;
                        end
                        n_cnt = n_cnt + CNT_W'(1);
                    end
                    ST_CHECK: begin
                        n_win = {n_win[14:0], w_bit};
                        if (n_cnt == CNT_W'(PAYLOAD_BITS + UW_W - 1)) begin
                            n_cnt = '0;
                            if (n_win == (n_inv ? ~HEADER : HEADER)) begin
                                n_miss  = '0;
                                n_state = ST_PAYLOAD;
                            end else if (n_miss == MISS_W'(MISS_MAX)) begin
                                n_state = ST_SEARCH;
                                n_win   = '0;
                                n_sr    = '0;
                                n_inv   = 1'b0;
                                n_miss  = '0;
                            end else begin
                                n_miss  = n_miss + MISS_W'(1);
                                n_state = ST_PAYLOAD;
                            end
                        end else begin
                            n_cnt = n_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        n_state = ST_SEARCH;
                    end
                endcase
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SEARCH;
            r_cnt   <= '0;
            r_win   <= '0;
            r_sr    <= '0;
            r_inv   <= 1'b0;
            r_miss  <= '0;
        end else begin
            r_state <= n_state;
            r_cnt   <= n_cnt;
            r_win   <= n_win[14:0];
            r_sr    <= n_sr;
            r_inv   <= n_inv;
            r_miss  <= n_miss;
        end
    end

    // Byte output registers: strobes land the cycle after the completing symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_out    <= 8'h00;
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_byte_valid  <= w_byte_done;
            r_frame_start <= w_byte_done & w_byte_first;
            if (w_byte_done) begin
                r_byte_out <= w_byte_data;
            end
        end
    end

    assign o_byte_out    = r_byte_out;
    assign o_byte_valid  = r_byte_valid;
    assign o_frame_start = r_frame_start;
    assign o_lock        = (r_state != ST_SEARCH);
    assign o_inverted    = r_inv;
    assign o_state       = r_state;

endmodule

// File: doc/qpsk_frame_sync.md
QPSK_FRAME_SYNC -- requirements
Module: qpsk_frame_sync

Interface
REQ-001 Parameter HEADER, default 16'hEB90: frame unique word, sent MSB first.
REQ-002 Parameter PAYLOAD_BYTES, default 8: payload bytes following each header.
REQ-003 Parameter MISS_MAX, default 2: consecutive missed headers tolerated while locked.
REQ-004 clk  input  1  symbol-rate system clock (500 kHz, same clock as the timing-recovery stage).
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 sync_out_I  input  1  hard-decided I bit from the Gardner timing-recovery stage.
REQ-007 sync_out_Q  input  1  hard-decided Q bit from the Gardner timing-recovery stage.
REQ-008 sync_flag  input  1  optimum-sample strobe; I/Q are valid only in cycles where it is high.
REQ-009 byte_out  output  8  descrambled payload byte, MSB = earliest bit.
REQ-010 byte_valid  output  1  one-cycle strobe qualifying byte_out.
REQ-011 frame_start  output  1  one-cycle strobe coinciding with byte_valid of payload byte 0.
REQ-012 lock  output  1  high while frame alignment is held.
REQ-013 inverted  output  1  high when the current lock was acquired on ~HEADER (180° phase ambiguity).

Function
REQ-014 Each sync_flag cycle contributes two serial bits, I first, then Q; cycles without sync_flag contribute none.
REQ-015 Bits are processed as one stream; frame alignment may start on either the I bit or the Q bit.
REQ-016 FSM states: SEARCH, PAYLOAD, CHECK.
REQ-017 SEARCH: 16-bit window compared after every bit, both bit positions of a symbol evaluated in the same cycle; match with HEADER -> PAYLOAD, inverted=0; match with ~HEADER -> PAYLOAD, inverted=1; lock=1.
REQ-018 A match ending on the I bit makes the Q bit of the same symbol payload bit 0.
REQ-019 If HEADER and ~HEADER both match within one symbol, the earlier bit position wins.
REQ-020 PAYLOAD: counts PAYLOAD_BYTES*8 bits; each bit XORed with inverted before byte assembly; byte_valid pulses the cycle after the sync_flag cycle that supplied the byte's 8th bit.
REQ-021 At most one byte completes per sync_flag; byte_valid is never asserted on consecutive cycles.
REQ-022 After the last payload bit -> CHECK: the next 16 bits are compared against the header polarity of the current lock only.
REQ-023 CHECK match: miss counter cleared -> PAYLOAD.
REQ-024 CHECK mismatch: miss counter +1; counter <= MISS_MAX -> PAYLOAD (flywheel, alignment kept); counter > MISS_MAX -> SEARCH, lock=0, inverted=0, bit counters and window cleared.
REQ-025 Window and bit counter hold their values in cycles without sync_flag.
REQ-026 Bit counter width is clog2(PAYLOAD_BYTES*8+16); no wrap-around inside a frame.

Reset
REQ-027 rst_n low: state=SEARCH, window=0, counters=0, byte_out=0, byte_valid=0, frame_start=0, lock=0, inverted=0, effective immediately.
REQ-028 Reset asserted mid-frame discards the partial byte; no byte_valid is produced for it after release.

Structure
REQ-029 A shared package holds the FSM state encoding, the default HEADER constant and a bits-per-symbol constant (2).
REQ-030 One sub-module, qpsk_uw_detect: combinational dual-position window compare returning {match, match_inv, position}.

Verification
REQ-031 Clean stream: 0xEB90 + bytes 0x01..0x08 at I-aligned start -> lock rises, 8 byte_valid, frame_start with 0x01, bytes 0x01..0x08 in order.
REQ-032 Q-aligned start, i.e. one leading pad bit before the header -> same 8 bytes received, proving odd alignment.
REQ-033 Inverted stream, all bits complemented -> inverted=1, bytes 0x01..0x08 recovered uncomplemented.
REQ-034 Locked, then 3 consecutive corrupted headers with MISS_MAX=2 -> frames 1-2 still output, lock drops after the third CHECK, state=SEARCH.
REQ-035 sync_flag gaps of 0-3 idle cycles between symbols -> identical bytes; byte_valid never on back-to-back cycles.
REQ-036 rst_n pulsed low at payload byte 4 -> all outputs 0 immediately, reacquisition on the next header.
